decode_issue_stage: RTL and testbench

//  Decode/register-fetch stage directly upstream of the ALU. Accepts 32-bit MIPS-style instructions

---
 rtl/decode_issue_stage.sv | 159 +++++++++++++++
 tb/tb_decode_issue_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// decode_issue_stage
//   Decode / register-fetch stage that feeds the ALU. It decodes a MIPS-style
//   instruction, reads rs/rt from the register file, and loads A, B, immediate,
//   ALUOp and dest into an output register on a valid/ready handshake.
//   A busy-bit scoreboard blocks issue while a source is still owed a result
//   by writeback.
// Ports
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     fetch-side handshake, in_instr is the instruction
//   out_valid/out_ready   ALU-side handshake for the output register
//   A, B, immediate       operands (B and immediate zero when unused)
//   ALUOp                 00 add, 01 sub, 10 add-imm, 11 invalid
//   dest, dest_we         destination register and write-back request
//   wb_en/wb_addr/wb_data writeback port into the register file
module decode_issue_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [15:0]       immediate,
  output logic [1:0]        ALUOp,
  output logic [ADDR_W-1:0] dest,
  output logic              dest_we,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [15:0]       imm;
  logic              unused_shamt;

  assign op    = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];
  assign rd    = in_instr[15:11];
  assign funct = in_instr[5:0];
  assign imm   = in_instr[15:0];
  assign unused_shamt = ^in_instr[10:6];

  logic              isAdd;
  logic              isSub;
  logic              isAddi;
  logic              isRtype;
  logic [1:0]        aluopNext;
  logic [ADDR_W-1:0] destNext;
  logic              destWeNext;
  logic [15:0]       immNext;

  assign isAdd   = (op == 6'h00) && (funct == 6'h20);
  assign isSub   = (op == 6'h00) && (funct == 6'h22);
  assign isAddi  = (op == 6'h08);
  assign isRtype = isAdd || isSub;

  always_comb begin
    aluopNext = OP_INV;
    destNext  = '0;
    immNext   = '0;
    if (isAdd) begin
      aluopNext = OP_ADD;
      destNext  = rd;
    end else if (isSub) begin
      aluopNext = OP_SUB;
      destNext  = rd;
    end else if (isAddi) begin
      aluopNext = OP_ADDI;
      destNext  = rt;
      immNext   = imm;
    end
  end

  assign destWeNext = (isRtype || isAddi) && (destNext != '0);

  // Source reads: reg 0 is constant zero, and a same-cycle writeback to the
  // source is forwarded so the consumer can issue in the clearing cycle.
  logic              wbHitRs;
  logic              wbHitRt;
  logic [DATA_W-1:0] rsVal;
  logic [DATA_W-1:0] rtVal;

  assign wbHitRs = wb_en && (wb_addr == rs) && (rs != '0);
  assign wbHitRt = wb_en && (wb_addr == rt) && (rt != '0);

  always_comb begin
    rsVal = '0;
    rtVal = '0;
    if (rs != '0) rsVal = wbHitRs ? wb_data : regs[rs];
    if (rt != '0) rtVal = wbHitRt ? wb_data : regs[rt];
  end

  // rt only counts as a source for R-type; rs is always treated as read.
  logic hazard;
  logic accept;

  assign hazard = ((rs != '0) && busy[rs] && !wbHitRs) ||
                  (isRtype && (rt != '0) && busy[rt] && !wbHitRt);

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      immediate <= '0;
      ALUOp     <= OP_INV;
      dest      <= '0;
      dest_we   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      A         <= rsVal;
      B         <= isRtype ? rtVal : '0;
      immediate <= immNext;
      ALUOp     <= aluopNext;
      dest      <= destNext;
      dest_we   <= destWeNext;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Register file and scoreboard. The busy set is written after the clear so
  // that a new producer claiming the same register in this cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wb_en && (wb_addr != '0)) begin
        regs[wb_addr] <= wb_data;
        busy[wb_addr] <= 1'b0;
      end
      if (accept && destWeNext) busy[destNext] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage
//   Directed bench for decode_issue_stage: register writes through writeback,
//   issue of add/sub/addi/invalid, RAW stall and bypass, output hold under
//   backpressure, set-wins scoreboard collision and reset mid-operation.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [15:0] immediate;
  logic [1:0]  ALUOp;
  logic [4:0]  dest;
  logic        dest_we;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  decode_issue_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A         (A),
    .B         (B),
    .immediate (immediate),
    .ALUOp     (ALUOp),
    .dest      (dest),
    .dest_we   (dest_we),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic ordy,
                               input logic wbe, input logic [4:0] wba, input logic [31:0] wbd);
    in_valid  = v;
    in_instr  = instr;
    out_ready = ordy;
    wb_en     = wbe;
    wb_addr   = wba;
    wb_data   = wbd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_aluop", {30'd0, ALUOp}, 32'd3);
    checkOutput("rst_A", A, 32'd0);
    checkOutput("rst_dest_we", {31'd0, dest_we}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Test 1: load R1=5, R2=3 then add r3,r1,r2
    $display("[TB] test 1: add r3,r1,r2");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd1, 32'd5);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd2, 32'd3);
    tick();
    applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t1_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t1_A", A, 32'd5);
    checkOutput("t1_B", B, 32'd3);
    checkOutput("t1_aluop", {30'd0, ALUOp}, 32'd0);
    checkOutput("t1_dest", {27'd0, dest}, 32'd3);
    checkOutput("t1_dest_we", {31'd0, dest_we}, 32'd1);
    checkOutput("t1_imm", {16'd0, immediate}, 32'd0);

    // Test 2: sub r4,r3,r1 stalls on r3 until writeback, then bypasses
    $display("[TB] test 2: RAW stall and bypass");
    applyStimulus(1'b1, rtype(5'd3, 5'd1, 5'd4, 6'h22), 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t2_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("t2_drained", {31'd0, out_valid}, 32'd0);
    checkOutput("t2_stall1", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b1, rtype(5'd3, 5'd1, 5'd4, 6'h22), 1'b1, 1'b1, 5'd3, 32'd8);
    checkOutput("t2_bypass_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t2_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t2_A", A, 32'd8);
    checkOutput("t2_B", B, 32'd5);
    checkOutput("t2_aluop", {30'd0, ALUOp}, 32'd1);
    checkOutput("t2_dest", {27'd0, dest}, 32'd4);

    // Test 3: backpressure holds the output for three cycles
    $display("[TB] test 3: backpressure");
    applyStimulus(1'b1, itype(6'h08, 5'd1, 5'd6, 16'h0007), 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("t3_in_ready_held", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("t3_hold_A", A, 32'd8);
      checkOutput("t3_hold_aluop", {30'd0, ALUOp}, 32'd1);
      checkOutput("t3_hold_dest", {27'd0, dest}, 32'd4);
      checkOutput("t3_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    applyStimulus(1'b1, itype(6'h08, 5'd1, 5'd6, 16'h0007), 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t3_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t3_aluop", {30'd0, ALUOp}, 32'd2);
    checkOutput("t3_A", A, 32'd5);
    checkOutput("t3_B", B, 32'd0);
    checkOutput("t3_imm", {16'd0, immediate}, 32'h0007);
    checkOutput("t3_dest", {27'd0, dest}, 32'd6);
    checkOutput("t3_dest_we", {31'd0, dest_we}, 32'd1);

    // Test 4: addi to r0 and an invalid opcode
    $display("[TB] test 4: addi r0 and invalid op");
    applyStimulus(1'b1, itype(6'h08, 5'd1, 5'd0, 16'h0007), 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t4_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t4_aluop", {30'd0, ALUOp}, 32'd2);
    checkOutput("t4_imm", {16'd0, immediate}, 32'h0007);
    checkOutput("t4_dest", {27'd0, dest}, 32'd0);
    checkOutput("t4_dest_we", {31'd0, dest_we}, 32'd0);
    applyStimulus(1'b0, rtype(5'd6, 5'd1, 5'd8, 6'h20), 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t4_r6_still_busy", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b1, itype(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t4_inv_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t4_inv_aluop", {30'd0, ALUOp}, 32'd3);
    checkOutput("t4_inv_A", A, 32'd5);
    checkOutput("t4_inv_B", B, 32'd0);
    checkOutput("t4_inv_imm", {16'd0, immediate}, 32'd0);
    checkOutput("t4_inv_dest_we", {31'd0, dest_we}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd4, 32'h11);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 5'd6, 32'h22);
    tick();

    // Test 5: producer of r5 accepted in the same cycle as wb to r5
    $display("[TB] test 5: set wins over clear");
    applyStimulus(1'b1, itype(6'h08, 5'd1, 5'd5, 16'h0001), 1'b1, 1'b1, 5'd5, 32'h55);
    checkOutput("t5_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t5_dest", {27'd0, dest}, 32'd5);
    applyStimulus(1'b1, rtype(5'd5, 5'd1, 5'd9, 6'h20), 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t5_consumer_stall", {31'd0, in_ready}, 32'd0);
    tick();
    applyStimulus(1'b1, rtype(5'd5, 5'd1, 5'd9, 6'h20), 1'b1, 1'b1, 5'd5, 32'h66);
    checkOutput("t5_clear_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t5_A", A, 32'h66);
    checkOutput("t5_B", B, 32'd5);

    // Test 6: reset while holding an output and with r3 busy
    $display("[TB] test 6: reset mid-operation");
    applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, rtype(5'd3, 5'd1, 5'd10, 6'h20), 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("t6_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t6_aluop", {30'd0, ALUOp}, 32'd3);
    checkOutput("t6_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t6_A_r3", A, 32'd0);
    checkOutput("t6_B_r1", B, 32'd0);
    checkOutput("t6_dest", {27'd0, dest}, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
